// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a registered-read DataMemory.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention, else port 0 has fixed priority.
module dmem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int MEM_DEPTH = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              M0_REQ,
    input  logic              M0_WE,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [DATA_W-1:0] M0_WDATA,
    output logic              M0_ACK,
    output logic              M0_ERR,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_REQ,
    input  logic              M1_WE,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M1_ACK,
    output logic              M1_ERR,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

    state_t             state;
    logic               grant;
    logic               lat_we;
    logic               pick;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [DATA_W-1:0]  wait_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic               last;
`endif

    // Grant selection among the currently requesting ports
    always_comb begin
        pick = 1'b0;
        if (M0_REQ && M1_REQ) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = ~last;
`else
            pick = 1'b0;
`endif
        end else if (M1_REQ) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

    // Request fields of the selected port; writes echo their own data back
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = {ADDR_W{1'b0}};
        sel_wdata = {DATA_W{1'b0}};
        if (pick) begin
            sel_we    = M1_WE;
            sel_addr  = M1_ADDR;
            sel_wdata = M1_WDATA;
        end else begin
            sel_we    = M0_WE;
            sel_addr  = M0_ADDR;
            sel_wdata = M0_WDATA;
        end
        if (lat_we) begin
            wait_data = MEM_WDATA;
        end else begin
            wait_data = MEM_RDATA;
        end
    end

    // Transaction sequencer with registered memory strobes and per-port responses
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            grant     <= 1'b0;
            lat_we    <= 1'b0;
            M0_ACK    <= 1'b0;
            M0_ERR    <= 1'b0;
            M0_RDATA  <= {DATA_W{1'b0}};
            M1_ACK    <= 1'b0;
            M1_ERR    <= 1'b0;
            M1_RDATA  <= {DATA_W{1'b0}};
            MEM_RD    <= 1'b0;
            MEM_WR    <= 1'b0;
            MEM_ADDR  <= {ADDR_W{1'b0}};
            MEM_WDATA <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last      <= 1'b1;
`endif
        end else begin
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            M0_ACK <= 1'b0;
            M0_ERR <= 1'b0;
            M1_ACK <= 1'b0;
            M1_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (M0_REQ || M1_REQ) begin
                        grant  <= pick;
                        lat_we <= sel_we;
`ifdef ARB_ROUND_ROBIN_EN
                        last   <= pick;
`endif
                        if (sel_addr < DEPTH) begin
                            MEM_ADDR  <= sel_addr;
                            MEM_WDATA <= sel_wdata;
                            MEM_RD    <= ~sel_we;
                            MEM_WR    <= sel_we;
                            state     <= ISSUE;
                        end else begin
                            // Out-of-range: answer immediately, memory untouched
                            if (pick) begin
                                M1_ACK   <= 1'b1;
                                M1_ERR   <= 1'b1;
                                M1_RDATA <= {DATA_W{1'b0}};
                            end else begin
                                M0_ACK   <= 1'b1;
                                M0_ERR   <= 1'b1;
                                M0_RDATA <= {DATA_W{1'b0}};
                            end
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (grant) begin
                        M1_ACK   <= 1'b1;
                        M1_RDATA <= wait_data;
                    end else begin
                        M0_ACK   <= 1'b1;
                        M0_RDATA <= wait_data;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus two random requesters
// checked against a shadow-memory scoreboard updated in ACK order.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        M0_REQ, M0_WE, M0_ACK, M0_ERR;
    logic [10:0] M0_ADDR;
    logic [15:0] M0_WDATA, M0_RDATA;
    logic        M1_REQ, M1_WE, M1_ACK, M1_ERR;
    logic [10:0] M1_ADDR;
    logic [15:0] M1_WDATA, M1_RDATA;
    logic        MEM_RD, MEM_WR;
    logic [10:0] MEM_ADDR;
    logic [15:0] MEM_WDATA, MEM_RDATA;

    logic [15:0] mem     [0:9];
    logic [15:0] ref_mem [0:9];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0, rd_cnt = 0;
    int ack_cnt0 = 0, ack_cnt1 = 0;
    logic [10:0] last_strobe_addr = 11'd0;

    dmem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_ACK(M0_ACK), .M0_ERR(M0_ERR), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_ACK(M1_ACK), .M1_ERR(M1_ERR), .M1_RDATA(M1_RDATA),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // DataMemory stand-in: registered read, outputs 0 when not reading
    always @(posedge CLK) begin
        if (MEM_WR && MEM_ADDR < 11'd10) mem[MEM_ADDR[3:0]] <= MEM_WDATA;
        if (MEM_RD && MEM_ADDR < 11'd10) MEM_RDATA <= mem[MEM_ADDR[3:0]];
        else MEM_RDATA <= 16'h0000;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle-by-cycle invariants and event counters
    always @(negedge CLK) begin
        if (!RESET) begin
            check_eq("strobe_excl", {31'd0, MEM_RD & MEM_WR}, 32'd0);
            check_eq("ack_excl", {31'd0, M0_ACK & M1_ACK}, 32'd0);
            if (MEM_RD || MEM_WR) begin
                check_eq("strobe_addr_range", {31'd0, MEM_ADDR >= 11'd10}, 32'd0);
                last_strobe_addr = MEM_ADDR;
            end
            if (MEM_WR) wr_cnt++;
            if (MEM_RD) rd_cnt++;
            if (M0_ACK) ack_cnt0++;
            if (M1_ACK) ack_cnt1++;
        end
    end

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [10:0] addr, input logic [15:0] wd);
        if (p == 0) begin
            M0_REQ = req; M0_WE = we; M0_ADDR = addr; M0_WDATA = wd;
        end else begin
            M1_REQ = req; M1_WE = we; M1_ADDR = addr; M1_WDATA = wd;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? M0_ACK : M1_ACK;
    endfunction

    // One transaction; caller is at a negedge. exp_lat > 0 also checks ACK latency.
    task automatic do_txn(input int p, input logic we, input logic [10:0] addr,
                          input logic [15:0] wd, input string tag, input int exp_lat);
        int n = 0;
        logic exp_err;
        logic [15:0] exp_rd;
        set_port(p, 1'b1, we, addr, wd);
        forever begin
            @(negedge CLK);
            n++;
            if (ack_of(p)) break;
            if (n > 400) break;
        end
        check_eq({tag, "_ack_seen"}, {31'd0, ack_of(p)}, 32'd1);
        exp_err = (addr >= 11'd10);
        exp_rd  = 16'h0000;
        if (!exp_err) begin
            if (we) begin
                exp_rd = wd;
                ref_mem[addr[3:0]] = wd;
            end else begin
                exp_rd = ref_mem[addr[3:0]];
            end
        end
        check_eq({tag, "_err"}, {31'd0, (p == 0) ? M0_ERR : M1_ERR}, {31'd0, exp_err});
        check_eq({tag, "_rdata"}, {16'd0, (p == 0) ? M0_RDATA : M1_RDATA}, {16'd0, exp_rd});
        if (exp_lat > 0) check_eq({tag, "_latency"}, n, exp_lat);
        set_port(p, 1'b0, $urandom_range(1, 0), 11'($urandom_range(12, 0)), 16'($urandom));
        @(negedge CLK);
        check_eq({tag, "_ack_pulse"}, {31'd0, ack_of(p)}, 32'd0);
    endtask

    task automatic outs_zero(input string tag);
        check_eq(tag, {31'd0, |{M0_ACK, M0_ERR, M0_RDATA, M1_ACK, M1_ERR, M1_RDATA,
                                MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA}}, 32'd0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(negedge CLK);
        outs_zero("reset_outs");
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic agent(input int p, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge CLK);
            do_txn(p, 1'($urandom_range(1, 0)), 11'($urandom_range(12, 0)),
                   16'($urandom), (p == 0) ? "rnd0" : "rnd1", 0);
        end
    endtask

    initial begin
        int w0, ackq_n[$], ackq_p[$];
        logic [15:0] ackq_d[$];
        int b0, b1;
        for (int i = 0; i < 10; i++) begin
            mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        RESET = 1'b1;
        set_port(0, 1'b0, 1'b0, 11'd0, 16'h0);
        set_port(1, 1'b0, 1'b0, 11'd0, 16'h0);
        repeat (2) @(negedge CLK);
        outs_zero("init_reset_outs");
        RESET = 1'b0;
        @(negedge CLK);

        // Write then read back through port 0
        w0 = wr_cnt;
        do_txn(0, 1'b1, 11'd3, 16'hBEEF, "t1_wr", 3);
        check_eq("t1_wr_strobes", wr_cnt - w0, 1);
        check_eq("t1_wr_addr", {21'd0, last_strobe_addr}, 32'd3);
        do_txn(0, 1'b0, 11'd3, 16'h0000, "t1_rd", 3);

        // Out-of-range on port 1: immediate error, no strobes
        w0 = wr_cnt + rd_cnt;
        do_txn(1, 1'b0, 11'd10, 16'h0000, "t2_oor", 1);
        check_eq("t2_no_strobe", wr_cnt + rd_cnt - w0, 0);
        do_txn(0, 1'b1, 11'd2047, 16'h5A5A, "t2_oor_max", 1);
        do_txn(1, 1'b1, 11'd9, 16'h9999, "t2_top_word", 3);

        // Contention with both requests held continuously
        do_txn(0, 1'b1, 11'd1, 16'h1111, "t3_setup1", 3);
        do_txn(1, 1'b1, 11'd2, 16'h2222, "t3_setup2", 3);
        do_reset();
        M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 11'd1;
        M1_REQ = 1'b1; M1_WE = 1'b0; M1_ADDR = 11'd2;
        for (int c = 1; c <= 17; c++) begin
            @(negedge CLK);
            if (M0_ACK) begin ackq_n.push_back(c); ackq_p.push_back(0); ackq_d.push_back(M0_RDATA); end
            if (M1_ACK) begin ackq_n.push_back(c); ackq_p.push_back(1); ackq_d.push_back(M1_RDATA); end
        end
        M0_REQ = 1'b0; M1_REQ = 1'b0;
        check_eq("t3_ack_count", ackq_n.size(), 4);
        for (int k = 0; k < 4 && k < ackq_n.size(); k++) begin
            int ep;
`ifdef ARB_ROUND_ROBIN_EN
            ep = k % 2;
`else
            ep = 0;
`endif
            check_eq("t3_ack_cycle", ackq_n[k], 3 + 4 * k);
            check_eq("t3_ack_port", ackq_p[k], ep);
            check_eq("t3_ack_data", {16'd0, ackq_d[k]}, (ep == 0) ? 32'h1111 : 32'h2222);
        end
        repeat (8) @(negedge CLK);

        // Reset during ISSUE of a port-1 write
        set_port(1, 1'b1, 1'b1, 11'd5, 16'h1234);
        @(negedge CLK);
        check_eq("t4_in_issue", {31'd0, MEM_WR}, 32'd1);
        RESET = 1'b1;
        #1;
        outs_zero("t4_async_outs");
        M1_REQ = 1'b0;
        @(negedge CLK);
        outs_zero("t4_reset_outs");
        RESET = 1'b0;
        w0 = ack_cnt1;
        repeat (4) @(negedge CLK);
        check_eq("t4_no_ack", ack_cnt1 - w0, 0);
        check_eq("t4_no_write", {16'd0, mem[5]}, {16'd0, ref_mem[5]});
        do_txn(1, 1'b1, 11'd5, 16'h1234, "t4_reissue", 3);
        do_txn(0, 1'b0, 11'd5, 16'h0000, "t4_readback", 3);

        // Random traffic from both ports against the scoreboard
        b0 = ack_cnt0;
        b1 = ack_cnt1;
        fork
            agent(0, 700);
            agent(1, 700);
        join
        repeat (4) @(negedge CLK);
        check_eq("t5_acks_port0", ack_cnt0 - b0, 700);
        check_eq("t5_acks_port1", ack_cnt1 - b1, 700);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
